// File: rtl/i2s_pkg.sv
// Shared I2S definitions: controller state encoding and slot-position constants,
// common to the microphone (RX) side and the TX side.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAKE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } i2s_state_t;

  // Slot bit 0 is the one-period I2S delay; data begins on the following bit
  localparam int SLOT_DELAY_BIT = 0;
  localparam int SLOT_MSB_BIT   = 1;

  function automatic int slot_bit(input int frame_bit, input int word_size);
    return (frame_bit >= word_size) ? frame_bit - word_size : frame_bit;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK divider: toggles BCLK every CLK_DIV clk cycles while running and flags
// the single clk cycle that ends with a BCLK rise or fall.
module i2s_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic BCLK,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          div_wrap;

  assign div_wrap  = run && (div == DIV_LAST);
  assign rise_tick = div_wrap && !BCLK;
  assign fall_tick = div_wrap && BCLK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      BCLK <= 1'b0;
    end else if (!run) begin
      div  <= '0;
      BCLK <= 1'b0;
    end else if (div_wrap) begin
      div  <= '0;
      BCLK <= ~BCLK;
    end else begin
      div  <= div + DW'(1);
    end
  end

endmodule

// File: rtl/i2s_mic_ctrl.sv
// I2S microphone receiver: generates BCLK/LRCLK, discards the wake-up frames,
// captures MSB-first samples from SD and hands them out over valid/ready.
module i2s_mic_ctrl
  import i2s_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int BIT_DEPTH      = 18,
  parameter int WORD_SIZE      = 32,
  parameter int STARTUP_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 SD,
  output logic                 BCLK,
  output logic                 LRCLK,
  output logic [BIT_DEPTH-1:0] sample_data,
  output logic                 sample_right,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(2 * WORD_SIZE);
  localparam int FW = (STARTUP_FRAMES > 2) ? $clog2(STARTUP_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_BIT        = CW'(2 * WORD_SIZE - 1);
  localparam logic [CW-1:0] RIGHT_FIRST_BIT = CW'(WORD_SIZE);
  localparam logic [FW-1:0] LAST_WAKE_FRAME = FW'((STARTUP_FRAMES > 0) ? STARTUP_FRAMES - 1 : 0);

  i2s_state_t state, state_nxt;
  logic                 from_run, from_run_nxt;
  logic                 run, rise_tick, fall_tick;
  logic [CW-1:0]        bit_cnt, bit_nxt;
  logic [FW-1:0]        frame_cnt;
  logic                 wrap, wake_done, capture_en, in_data, complete;
  logic [BIT_DEPTH-1:0] shift_reg;
  int                   slot;

  assign run  = (state != ST_IDLE);
  assign busy = run;

  i2s_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .BCLK     (BCLK),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  assign bit_nxt    = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
  assign wrap       = fall_tick && (bit_cnt == LAST_BIT);
  assign wake_done  = (STARTUP_FRAMES == 0) || (frame_cnt == LAST_WAKE_FRAME);
  assign slot       = slot_bit(int'(bit_cnt), WORD_SIZE);
  assign in_data    = (slot >= SLOT_MSB_BIT) && (slot <= BIT_DEPTH);
  // Draining from WAKE never delivers; draining from RUN finishes the frame's samples
  assign capture_en = (state == ST_RUN) || ((state == ST_DRAIN) && from_run);
  assign complete   = capture_en && rise_tick && (slot == BIT_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      from_run <= 1'b0;
    end else begin
      state    <= state_nxt;
      from_run <= from_run_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    from_run_nxt = from_run;
    case (state)
      ST_IDLE: begin
        from_run_nxt = 1'b0;
        if (enable) state_nxt = (STARTUP_FRAMES == 0) ? ST_RUN : ST_WAKE;
      end
      ST_WAKE: begin
        if (!enable) begin
          state_nxt    = ST_DRAIN;
          from_run_nxt = 1'b0;
        end else if (wrap && wake_done) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_nxt    = ST_DRAIN;
          from_run_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (enable) begin
          if (from_run || (wrap && wake_done)) state_nxt = ST_RUN;
          else                                 state_nxt = ST_WAKE;
        end else if (wrap) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Wake-up frames are counted while discarding, including a WAKE-side drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (state == ST_IDLE) begin
      frame_cnt <= '0;
    end else if (wrap && !wake_done &&
                 ((state == ST_WAKE) || ((state == ST_DRAIN) && !from_run))) begin
      frame_cnt <= frame_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      LRCLK     <= 1'b0;
      shift_reg <= '0;
    end else if (state == ST_IDLE) begin
      bit_cnt   <= '0;
      LRCLK     <= 1'b0;
      shift_reg <= '0;
    end else begin
      if (fall_tick) begin
        bit_cnt <= bit_nxt;
        LRCLK   <= (bit_nxt >= RIGHT_FIRST_BIT);
      end
      if (capture_en && rise_tick && in_data) shift_reg <= {shift_reg[BIT_DEPTH-2:0], SD};
    end
  end

  // A held, unaccepted sample wins over a newly completed one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_data  <= '0;
      sample_right <= 1'b0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= complete && sample_valid && !sample_ready;
      if (complete && (!sample_valid || sample_ready)) begin
        sample_data  <= {shift_reg[BIT_DEPTH-2:0], SD};
        sample_right <= LRCLK;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_mic_ctrl.sv
// Bench for i2s_mic_ctrl: a timeline-based microphone/consumer model predicts
// every output each cycle while directed phases exercise wake, drain and reset.
module tb_i2s_mic_ctrl;

  localparam int CLK_DIV     = 4;
  localparam int BIT_DEPTH   = 18;
  localparam int WORD_SIZE   = 32;
  localparam int STARTUP     = 1;
  localparam int BIT_CYC     = 2 * CLK_DIV;
  localparam int FRAME_BITS  = 2 * WORD_SIZE;
  localparam int FRAME_CYC   = BIT_CYC * FRAME_BITS;
  localparam int FIRST_VALID = 1 + CLK_DIV + BIT_CYC * (STARTUP * FRAME_BITS + BIT_DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic sd = 1'b0;
  logic sample_ready = 1'b0;
  logic BCLK, LRCLK, sample_right, sample_valid, overrun, busy;
  logic [BIT_DEPTH-1:0] sample_data;

  int compared = 0;
  int mismatched = 0;
  int unsigned rdy_pct = 100;

  // Reference timeline: m_t counts clk cycles since the interface left IDLE
  bit                   m_active = 1'b0;
  int                   m_t = 0;
  logic                 m_valid = 1'b0;
  logic [BIT_DEPTH-1:0] m_data = '0;
  logic                 m_right = 1'b0;
  logic                 m_ovr = 1'b0;
  logic [BIT_DEPTH-1:0] left_w[16];
  logic [BIT_DEPTH-1:0] right_w[16];

  always #5 clk = ~clk;

  i2s_mic_ctrl #(
    .CLK_DIV(CLK_DIV),
    .BIT_DEPTH(BIT_DEPTH),
    .WORD_SIZE(WORD_SIZE),
    .STARTUP_FRAMES(STARTUP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .SD(sd),
    .BCLK(BCLK),
    .LRCLK(LRCLK),
    .sample_data(sample_data),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun(overrun),
    .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [BIT_DEPTH-1:0] slotWord(input int frame, input bit right);
    return right ? right_w[frame % 16] : left_w[frame % 16];
  endfunction

  task automatic applyStimulus(input bit en, input int unsigned pct);
    @(negedge clk);
    enable  = en;
    rdy_pct = pct;
  endtask

  task automatic waitPos(input int pos, input int min_frame, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_active && ((m_t / BIT_CYC) % FRAME_BITS == pos) &&
                 ((m_t / BIT_CYC) / FRAME_BITS >= min_frame)) && n < 6000);
    if (n >= 6000) checkOutput(tag, 32'(0), 32'(1));
  endtask

  task automatic waitValid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 2000);
  endtask

  // Model: frames after the startup count deliver both slots; the stream stops
  // at the first frame boundary seen with enable low.
  initial begin : model
    bit compl;
    bit cr;
    logic [BIT_DEPTH-1:0] cd;
    int p;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0;
        m_t      = 0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_right  = 1'b0;
        m_ovr    = 1'b0;
      end else begin
        compl = 1'b0;
        cr    = 1'b0;
        cd    = '0;
        if (m_active) begin
          m_t++;
          if (m_t % BIT_CYC == CLK_DIV) begin
            p = m_t / BIT_CYC;
            if ((p / FRAME_BITS >= STARTUP) && (p % WORD_SIZE == BIT_DEPTH)) begin
              compl = 1'b1;
              cr    = (p % FRAME_BITS) >= WORD_SIZE;
              cd    = slotWord(p / FRAME_BITS, cr);
            end
          end
          if ((m_t % FRAME_CYC == 0) && !enable) m_active = 1'b0;
        end else if (enable) begin
          m_active = 1'b1;
          m_t      = 0;
        end
        m_ovr = 1'b0;
        if (compl) begin
          if (!m_valid || sample_ready) begin
            m_valid = 1'b1;
            m_data  = cd;
            m_right = cr;
          end else begin
            m_ovr = 1'b1;
          end
        end else if (m_valid && sample_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Microphone: MSB on slot bit 1, junk on every position the receiver must ignore
  initial begin : mic
    int p;
    int sb;
    logic [BIT_DEPTH-1:0] w;
    forever begin
      @(negedge clk);
      sd = 1'($urandom_range(0, 1));
      if (m_active) begin
        p  = m_t / BIT_CYC;
        sb = p % WORD_SIZE;
        if (sb >= 1 && sb <= BIT_DEPTH) begin
          w  = slotWord(p / FRAME_BITS, (p % FRAME_BITS) >= WORD_SIZE);
          sd = w[BIT_DEPTH - sb];
        end
      end
    end
  end

  initial begin : consumer
    forever begin
      @(negedge clk);
      sample_ready = ($urandom_range(1, 100) <= rdy_pct);
    end
  end

  initial begin : per_cycle
    forever begin
      @(negedge clk);
      checkOutput("bclk", 32'(BCLK), 32'(m_active && ((m_t / CLK_DIV) % 2 == 1)));
      checkOutput("lrclk", 32'(LRCLK), 32'(m_active && ((m_t / BIT_CYC) % FRAME_BITS >= WORD_SIZE)));
      checkOutput("busy", 32'(busy), 32'(m_active));
      checkOutput("valid", 32'(sample_valid), 32'(m_valid));
      checkOutput("overrun", 32'(overrun), 32'(m_ovr));
      if (m_valid) begin
        checkOutput("data", 32'(sample_data), 32'(m_data));
        checkOutput("right", 32'(sample_right), 32'(m_right));
      end
    end
  end

  initial begin : main
    int n;
    int vcount;
    int ovr_cnt;
    logic last_right;
    logic [BIT_DEPTH-1:0] held;
    for (int i = 0; i < 16; i++) begin
      left_w[i]  = BIT_DEPTH'($urandom);
      right_w[i] = BIT_DEPTH'($urandom);
    end
    left_w[1]  = 18'h2A5A5;
    right_w[1] = 18'h15A5A;

    repeat (3) @(negedge clk);
    checkOutput("rst_bclk", 32'(BCLK), 32'(0));
    checkOutput("rst_lrclk", 32'(LRCLK), 32'(0));
    checkOutput("rst_data", 32'(sample_data), 32'(0));
    checkOutput("rst_valid", 32'(sample_valid), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] wake-up and first samples");
    applyStimulus(1'b1, 100);
    waitValid(n);
    checkOutput("first_valid_latency", 32'(n), 32'(FIRST_VALID));
    checkOutput("first_left_data", 32'(sample_data), 32'(18'h2A5A5));
    checkOutput("first_left_right", 32'(sample_right), 32'(0));
    waitValid(n);
    checkOutput("left_right_gap", 32'(n), 32'(WORD_SIZE * BIT_CYC));
    checkOutput("first_right_data", 32'(sample_data), 32'(18'h15A5A));
    checkOutput("first_right_right", 32'(sample_right), 32'(1));

    $display("[TB] consumer stalled for two slots");
    applyStimulus(1'b1, 0);
    waitValid(n);
    held    = sample_data;
    ovr_cnt = 0;
    repeat (WORD_SIZE * BIT_CYC + 50) begin
      @(negedge clk);
      if (overrun) ovr_cnt++;
    end
    checkOutput("stall_overruns", 32'(ovr_cnt), 32'(1));
    checkOutput("stall_held_data", 32'(sample_data), 32'(held));
    checkOutput("stall_held_valid", 32'(sample_valid), 32'(1));

    $display("[TB] random backpressure");
    applyStimulus(1'b1, 50);
    repeat (4 * FRAME_CYC) @(negedge clk);
    applyStimulus(1'b1, 100);
    repeat (FRAME_CYC) @(negedge clk);

    $display("[TB] drain at bit 10");
    waitPos(10, 1, "wait_drain_pos");
    enable     = 1'b0;
    vcount     = 0;
    last_right = 1'b0;
    n          = 0;
    do begin
      @(negedge clk);
      n++;
      if (sample_valid) begin
        vcount++;
        last_right = sample_right;
      end
    end while (busy && n < 2 * FRAME_CYC);
    checkOutput("drain_reaches_idle", 32'(n < 2 * FRAME_CYC), 32'(1));
    checkOutput("drain_samples", 32'(vcount), 32'(2));
    checkOutput("drain_last_right", 32'(last_right), 32'(1));
    checkOutput("drain_bclk", 32'(BCLK), 32'(0));
    checkOutput("drain_busy", 32'(busy), 32'(0));

    $display("[TB] enable toggled within a frame");
    applyStimulus(1'b1, 100);
    waitPos(10, 1, "wait_toggle_pos");
    enable = 1'b0;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    vcount = 0;
    repeat (FRAME_CYC) begin
      @(negedge clk);
      if (sample_valid) vcount++;
    end
    checkOutput("toggle_samples", 32'(vcount), 32'(2));

    $display("[TB] reset at bit 20");
    waitPos(20, 1, "wait_reset_pos");
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    checkOutput("mid_rst_bclk", 32'(BCLK), 32'(0));
    checkOutput("mid_rst_lrclk", 32'(LRCLK), 32'(0));
    checkOutput("mid_rst_data", 32'(sample_data), 32'(0));
    checkOutput("mid_rst_right", 32'(sample_right), 32'(0));
    checkOutput("mid_rst_valid", 32'(sample_valid), 32'(0));
    checkOutput("mid_rst_overrun", 32'(overrun), 32'(0));
    checkOutput("mid_rst_busy", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("post_rst_idle", 32'(busy), 32'(0));
    checkOutput("post_rst_no_sample", 32'(sample_valid), 32'(0));
    applyStimulus(1'b1, 100);
    waitValid(n);
    checkOutput("rewake_latency", 32'(n), 32'(FIRST_VALID));
    checkOutput("rewake_left_data", 32'(sample_data), 32'(18'h2A5A5));
    repeat (FRAME_CYC / 2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
